// File: rtl/redmule_tile_iterator.sv
// redmule_tile_iterator
//   Walks an M x K x N tile space (m outer, k middle, n innermost) and
//   hands one tile descriptor per handshake to the scheduler. It also
//   counts the Z-tile stores, which happen on the last reduction step.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   clear_i            synchronous soft abort back to IDLE
//   cfg_valid_i/_ready_o  job configuration handshake (accepted in IDLE)
//   *_iter_i           tile counts per dimension
//   *_lftovr_i         last-tile size per dimension, 0 = full tile
//   tile_valid_o/_ready_i  descriptor handshake
//   tile_{m,k,n}_idx_o   tile coordinates
//   tile_{m,k,n}_size_o  effective tile sizes
//   tile_first_n_o / tile_last_n_o / tile_last_o  reduction/job markers
//   store_cnt_o        accepted descriptors carrying tile_last_n_o
//   busy_o, done_o     activity flag, one-cycle completion pulse
module redmule_tile_iterator #(
  parameter int unsigned ARRAY_WIDTH = 12,
  parameter int unsigned TILE_K      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [15:0] x_rows_iter_i,
  input  logic [15:0] w_cols_iter_i,
  input  logic [15:0] x_cols_iter_i,
  input  logic [7:0]  x_rows_lftovr_i,
  input  logic [7:0]  w_cols_lftovr_i,
  input  logic [7:0]  x_cols_lftovr_i,
  output logic        tile_valid_o,
  input  logic        tile_ready_i,
  output logic [15:0] tile_m_idx_o,
  output logic [15:0] tile_k_idx_o,
  output logic [15:0] tile_n_idx_o,
  output logic [7:0]  tile_m_size_o,
  output logic [7:0]  tile_k_size_o,
  output logic [7:0]  tile_n_size_o,
  output logic        tile_first_n_o,
  output logic        tile_last_n_o,
  output logic        tile_last_o,
  output logic [31:0] store_cnt_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      r_state, w_state_nxt;
  logic [15:0] r_m_iter, r_k_iter, r_n_iter;
  logic [7:0]  r_m_lft, r_k_lft, r_n_lft;
  logic [15:0] r_m_idx, r_k_idx, r_n_idx;
  logic [31:0] r_store_cnt;

  logic w_accept, w_zero_job, w_hs, w_cfg_ok;
  logic w_m_last, w_k_last, w_n_last, w_tile_last;

  function automatic logic [7:0] dim_size(input logic last, input logic [7:0] lft,
                                          input logic [7:0] full);
    return (last && lft != 8'd0) ? lft : full;
  endfunction

  assign w_accept   = (r_state == IDLE) && cfg_valid_i;
  assign w_zero_job = (x_rows_iter_i == 16'd0) || (w_cols_iter_i == 16'd0) ||
                      (x_cols_iter_i == 16'd0);
  assign w_hs       = (r_state == RUN) && tile_ready_i;

  // With a zero iteration count latched (reset state, empty job) there is
  // no meaningful tile, so flags and sizes read as zero.
  assign w_cfg_ok    = (r_m_iter != 16'd0) && (r_k_iter != 16'd0) && (r_n_iter != 16'd0);
  assign w_m_last    = w_cfg_ok && (r_m_idx == r_m_iter - 16'd1);
  assign w_k_last    = w_cfg_ok && (r_k_idx == r_k_iter - 16'd1);
  assign w_n_last    = w_cfg_ok && (r_n_idx == r_n_iter - 16'd1);
  assign w_tile_last = w_m_last && w_k_last && w_n_last;

  assign cfg_ready_o    = (r_state == IDLE);
  assign tile_valid_o   = (r_state == RUN);
  assign busy_o         = (r_state != IDLE);
  assign done_o         = (r_state == DONE);
  assign tile_m_idx_o   = r_m_idx;
  assign tile_k_idx_o   = r_k_idx;
  assign tile_n_idx_o   = r_n_idx;
  assign tile_m_size_o  = w_cfg_ok ? dim_size(w_m_last, r_m_lft, 8'(ARRAY_WIDTH)) : 8'd0;
  assign tile_k_size_o  = w_cfg_ok ? dim_size(w_k_last, r_k_lft, 8'(TILE_K)) : 8'd0;
  assign tile_n_size_o  = w_cfg_ok ? dim_size(w_n_last, r_n_lft, 8'(TILE_K)) : 8'd0;
  assign tile_first_n_o = w_cfg_ok && (r_n_idx == 16'd0);
  assign tile_last_n_o  = w_n_last;
  assign tile_last_o    = w_tile_last;
  assign store_cnt_o    = r_store_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cfg_valid_i) w_state_nxt = w_zero_job ? DONE : RUN;
      RUN:     if (w_hs && w_tile_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) r_state <= IDLE;
    else                  r_state <= w_state_nxt;
  end

  // Configuration is captured only on acceptance; a clear in the same
  // cycle wins and leaves the previous configuration in place.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m_iter <= '0; r_k_iter <= '0; r_n_iter <= '0;
      r_m_lft  <= '0; r_k_lft  <= '0; r_n_lft  <= '0;
    end else if (w_accept && !clear_i) begin
      r_m_iter <= x_rows_iter_i;   r_k_iter <= w_cols_iter_i;   r_n_iter <= x_cols_iter_i;
      r_m_lft  <= x_rows_lftovr_i; r_k_lft  <= w_cols_lftovr_i; r_n_lft  <= x_cols_lftovr_i;
    end
  end

  // Counters hold on the final handshake so the descriptor fields keep
  // showing the last tile while DONE/IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || w_accept) begin
      r_m_idx     <= '0;
      r_k_idx     <= '0;
      r_n_idx     <= '0;
      r_store_cnt <= '0;
    end else if (w_hs) begin
      if (w_n_last) r_store_cnt <= r_store_cnt + 32'd1;
      if (!w_tile_last) begin
        if (w_n_last) begin
          r_n_idx <= '0;
          if (w_k_last) begin
            r_k_idx <= '0;
            r_m_idx <= r_m_idx + 16'd1;
          end else begin
            r_k_idx <= r_k_idx + 16'd1;
          end
        end else begin
          r_n_idx <= r_n_idx + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_redmule_tile_iterator.sv
module tb_redmule_tile_iterator;

  logic        clk = 1'b0;
  logic        rst, clear, cfg_valid, cfg_ready, tile_valid, tile_ready;
  logic [15:0] m_iter, k_iter, n_iter;
  logic [7:0]  m_lft, k_lft, n_lft;
  logic [15:0] m_idx, k_idx, n_idx;
  logic [7:0]  m_size, k_size, n_size;
  logic        first_n, last_n, last_t, busy, done;
  logic [31:0] store_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  redmule_tile_iterator #(.ARRAY_WIDTH(12), .TILE_K(16)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .x_rows_iter_i(m_iter), .w_cols_iter_i(k_iter), .x_cols_iter_i(n_iter),
    .x_rows_lftovr_i(m_lft), .w_cols_lftovr_i(k_lft), .x_cols_lftovr_i(n_lft),
    .tile_valid_o(tile_valid), .tile_ready_i(tile_ready),
    .tile_m_idx_o(m_idx), .tile_k_idx_o(k_idx), .tile_n_idx_o(n_idx),
    .tile_m_size_o(m_size), .tile_k_size_o(k_size), .tile_n_size_o(n_size),
    .tile_first_n_o(first_n), .tile_last_n_o(last_n), .tile_last_o(last_t),
    .store_cnt_o(store_cnt), .busy_o(busy), .done_o(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cfg(input int m, k, n, input int ml, kl, nl);
    m_iter = 16'(m); k_iter = 16'(k); n_iter = 16'(n);
    m_lft = 8'(ml); k_lft = 8'(kl); n_lft = 8'(nl);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic exp_tile(input int m, k, n, input int ms, ks, ns,
                          input bit fn, ln, l);
    chk("valid",   tile_valid, 1);
    chk("m_idx",   m_idx, m);  chk("k_idx", k_idx, k);  chk("n_idx", n_idx, n);
    chk("m_size",  m_size, ms); chk("k_size", k_size, ks); chk("n_size", n_size, ns);
    chk("first_n", first_n, fn); chk("last_n", last_n, ln); chk("last", last_t, l);
  endtask

  task automatic exp_end(input int stores);
    chk("done_pulse", done, 1); chk("end_valid", tile_valid, 0);
    chk("end_store", store_cnt, stores); chk("end_ready", cfg_ready, 0);
    @(negedge clk);
    chk("done_gone", done, 0); chk("idle_ready", cfg_ready, 1);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; cfg_valid = 1'b0; tile_ready = 1'b0;
    m_iter = '0; k_iter = '0; n_iter = '0; m_lft = '0; k_lft = '0; n_lft = '0;
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_ready", cfg_ready, 1); chk("rst_valid", tile_valid, 0);
    chk("rst_store", store_cnt, 0); chk("rst_done", done, 0);
    chk("rst_busy", busy, 0); chk("rst_first", first_n, 0);
    chk("rst_msize", m_size, 0); chk("rst_nidx", n_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    // m=2,k=1,n=3 full tiles, ready held high
    tile_ready = 1'b1;
    cfg(2, 1, 3, 0, 0, 0);
    for (int m = 0; m < 2; m++)
      for (int n = 0; n < 3; n++) begin
        exp_tile(m, 0, n, 12, 16, 16, n == 0, n == 2, (m == 1) && (n == 2));
        @(negedge clk);
      end
    exp_end(2);

    // m=2,k=2,n=2 with leftovers 5/3/7
    cfg(2, 2, 2, 5, 3, 7);
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 2; k++)
        for (int n = 0; n < 2; n++) begin
          exp_tile(m, k, n, (m == 1) ? 5 : 12, (k == 1) ? 3 : 16, (n == 1) ? 7 : 16,
                   n == 0, n == 1, (m == 1) && (k == 1) && (n == 1));
          @(negedge clk);
        end
    exp_end(4);

    // backpressure on (0,0,1); a config offered mid-job must be ignored
    cfg(1, 1, 3, 0, 0, 0);
    exp_tile(0, 0, 0, 12, 16, 16, 1, 0, 0);
    @(negedge clk);
    tile_ready = 1'b0;
    m_iter = 16'd9; n_iter = 16'd9; n_lft = 8'd4; cfg_valid = 1'b1;
    repeat (3) begin
      exp_tile(0, 0, 1, 12, 16, 16, 0, 0, 0);
      chk("bp_store", store_cnt, 0);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    tile_ready = 1'b1;
    exp_tile(0, 0, 1, 12, 16, 16, 0, 0, 0);
    @(negedge clk);
    exp_tile(0, 0, 2, 12, 16, 16, 0, 1, 1);
    @(negedge clk);
    exp_end(1);

    // empty job: x_cols_iter=0
    cfg(2, 2, 0, 0, 0, 0);
    chk("zero_busy", busy, 1);
    exp_end(0);

    // clear after 2 of 6 handshakes (n=1 so every handshake stores)
    cfg(3, 2, 1, 0, 0, 0);
    exp_tile(0, 0, 0, 12, 16, 16, 1, 1, 0);
    @(negedge clk);
    exp_tile(0, 1, 0, 12, 16, 16, 1, 1, 0);
    @(negedge clk);
    chk("pre_clr_store", store_cnt, 2);
    chk("pre_clr_m", m_idx, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_ready", cfg_ready, 1); chk("clr_store", store_cnt, 0);
    chk("clr_done", done, 0); chk("clr_valid", tile_valid, 0);
    chk("clr_m", m_idx, 0); chk("clr_k", k_idx, 0);
    @(negedge clk);
    chk("clr_no_done", done, 0);
    cfg(1, 1, 2, 0, 0, 0);
    exp_tile(0, 0, 0, 12, 16, 16, 1, 0, 0);
    @(negedge clk);
    exp_tile(0, 0, 1, 12, 16, 16, 0, 1, 1);
    @(negedge clk);
    exp_end(1);

    // reset mid-job aborts
    cfg(2, 2, 2, 1, 1, 1);
    @(negedge clk);
    rst = 1'b1; clear = 1'b1;
    @(negedge clk);
    rst = 1'b0; clear = 1'b0;
    chk("abort_ready", cfg_ready, 1); chk("abort_valid", tile_valid, 0);
    chk("abort_nidx", n_idx, 0); chk("abort_nsize", n_size, 0);
    chk("abort_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
